// File: rtl/ecc_mod_sub_serial.sv
// Word-serial modular subtractor: res = (a - b) mod p.
// One RADIX-bit adder is time-shared: the SUB pass walks the words computing
// a - b with a ripple borrow; if the final borrow is set the result wrapped,
// so an ADD pass walks the words again adding p back in.
module ecc_mod_sub_serial #(
    parameter int unsigned REG_SIZE = 384,
    parameter int unsigned RADIX    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [REG_SIZE-1:0] a_i,
    input  logic [REG_SIZE-1:0] b_i,
    input  logic [REG_SIZE-1:0] p_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [REG_SIZE-1:0] res_o
);

    localparam int unsigned NUM_WORDS = REG_SIZE / RADIX;
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StSub, StAdd, StDone} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    // Borrow during SUB, carry during ADD; never needed at the same time.
    logic                cy_q;
    logic [REG_SIZE-1:0] a_q;
    logic [REG_SIZE-1:0] b_q;
    logic [REG_SIZE-1:0] p_q;
    logic [REG_SIZE-1:0] diff_q;
    logic [REG_SIZE-1:0] res_q;
    logic                busy_q;
    logic                done_q;

    logic [RADIX-1:0]    op_x;
    logic [RADIX-1:0]    op_y;
    logic                cin;
    logic [RADIX:0]      sum;
    logic [REG_SIZE-1:0] diff_shift;

    // Shared word datapath: subtraction is done as x + ~y + !borrow.
    always_comb begin
        op_x = a_q[RADIX-1:0];
        op_y = ~b_q[RADIX-1:0];
        cin  = ~cy_q;
        if (state_q == StAdd) begin
            op_x = diff_q[RADIX-1:0];
            op_y = p_q[RADIX-1:0];
            cin  = cy_q;
        end
        sum = {1'b0, op_x} + {1'b0, op_y} + {{RADIX{1'b0}}, cin};
        // New word enters at the top; after NUM_WORDS shifts word 0 is at the bottom.
        diff_shift = (diff_q >> RADIX) | (REG_SIZE'(sum[RADIX-1:0]) << (REG_SIZE - RADIX));
    end

    // Control FSM with registered outputs and operand shift registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            diff_q  <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        p_q     <= p_i;
                        cnt_q   <= '0;
                        cy_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StSub;
                    end
                end
                StSub: begin
                    a_q    <= a_q >> RADIX;
                    b_q    <= b_q >> RADIX;
                    diff_q <= diff_shift;
                    cy_q   <= ~sum[RADIX];
                    if (cnt_q == LAST_WORD) begin
                        cnt_q <= '0;
                        if (!sum[RADIX]) begin
                            // a < b: wrap back into range by adding p.
                            cy_q    <= 1'b0;
                            state_q <= StAdd;
                        end else begin
                            res_q   <= diff_shift;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAdd: begin
                    p_q    <= p_q >> RADIX;
                    diff_q <= diff_shift;
                    cy_q   <= sum[RADIX];
                    if (cnt_q == LAST_WORD) begin
                        // Final carry is the 2^REG_SIZE wrap; drop it.
                        cnt_q   <= '0;
                        cy_q    <= 1'b0;
                        res_q   <= diff_shift;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign res_o  = res_q;

endmodule

// File: tb/tb_ecc_mod_sub_serial.sv
// Self-checking bench for ecc_mod_sub_serial at 384/32 and 64/8.
module tb_ecc_mod_sub_serial;

    localparam logic [383:0] P384 =
        384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

    logic         clk = 1'b0;
    logic         reset;
    logic         start0, start1;
    logic [383:0] a0, b0, p0, res0;
    logic [63:0]  a1, b1, p1, res1;
    logic         busy0, done0, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ecc_mod_sub_serial #(.REG_SIZE(384), .RADIX(32)) dut0 (
        .clk(clk), .reset(reset), .start_i(start0), .a_i(a0), .b_i(b0), .p_i(p0),
        .busy_o(busy0), .done_o(done0), .res_o(res0)
    );

    ecc_mod_sub_serial #(.REG_SIZE(64), .RADIX(8)) dut1 (
        .clk(clk), .reset(reset), .start_i(start1), .a_i(a1), .b_i(b1), .p_i(p1),
        .busy_o(busy1), .done_o(done1), .res_o(res1)
    );

    task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [383:0] rnd384();
        logic [383:0] r = '0;
        for (int i = 0; i < 12; i++) r = {r[351:0], 32'($urandom())};
        return r;
    endfunction

    task automatic sample(input int which, output logic d, output logic bz, output logic [383:0] r);
        if (which == 0) begin
            d = done0; bz = busy0; r = res0;
        end else begin
            d = done1; bz = busy1; r = {320'd0, res1};
        end
    endtask

    task automatic drive(input int which, input logic s, input logic [383:0] a,
                         input logic [383:0] b, input logic [383:0] p);
        if (which == 0) begin
            start0 = s; a0 = a; b0 = b; p0 = p;
        end else begin
            start1 = s; a1 = a[63:0]; b1 = b[63:0]; p1 = p[63:0];
        end
    endtask

    // Called at a negedge; issues start and follows the operation to completion.
    // dist_cyc: cycle in which a stray start with other operands is driven.
    // rst_cyc:  cycle in which reset is asserted to abort the operation.
    task automatic run_op(input int which, input logic [383:0] a, input logic [383:0] b,
                          input logic [383:0] p, input int dist_cyc, input int rst_cyc,
                          input string tag);
        int           nw, lat_exp, cyc;
        logic [384:0] wide;
        logic [383:0] exp, r;
        logic         seen, busy_bad, d, bz;
        nw      = (which == 0) ? 12 : 8;
        wide    = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, p} - {1'b0, b};
        exp     = wide[383:0];
        lat_exp = (a >= b) ? nw + 1 : 2 * nw + 1;
        drive(which, 1'b1, a, b, p);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs so a design that failed to latch would compute garbage.
        drive(which, 1'b0, ~a, ~b, ~p);
        cyc = 1; seen = 1'b0; busy_bad = 1'b0;
        while (!seen && cyc <= 2 * nw + 4) begin
            sample(which, d, bz, r);
            if (!bz) busy_bad = 1'b1;
            if (d) begin
                seen = 1'b1;
            end else begin
                if (rst_cyc != 0 && cyc == rst_cyc) break;
                if (dist_cyc != 0 && cyc == dist_cyc) drive(which, 1'b1, 384'd1, 384'd9, p);
                else drive(which, 1'b0, ~a, ~b, ~p);
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        drive(which, 1'b0, ~a, ~b, ~p);
        if (rst_cyc != 0) begin
            check_eq({tag, "_no_early_done"}, {383'd0, seen}, 384'd0);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            sample(which, d, bz, r);
            check_eq({tag, "_abort_busy"}, {383'd0, bz}, 384'd0);
            check_eq({tag, "_abort_done"}, {383'd0, d}, 384'd0);
            check_eq({tag, "_abort_res"}, r, 384'd0);
            reset = 1'b0;
            return;
        end
        check_eq({tag, "_latency"}, seen ? 384'(cyc) : 384'd0, 384'(lat_exp));
        check_eq({tag, "_res"}, r, exp);
        check_eq({tag, "_busy_during"}, {383'd0, busy_bad}, 384'd0);
        @(posedge clk);
        @(negedge clk);
        sample(which, d, bz, r);
        check_eq({tag, "_busy_after"}, {383'd0, bz}, 384'd0);
        check_eq({tag, "_done_pulse"}, {383'd0, d}, 384'd0);
        check_eq({tag, "_res_hold"}, r, exp);
    endtask

    initial begin
        logic [383:0] ra, rb, rp;
        logic [63:0]  sa, sb, sp;
        logic         d, bz;
        logic [383:0] r;

        // Reset with start held high: reset must win.
        reset = 1'b1;
        drive(0, 1'b1, 384'd5, 384'd3, P384);
        drive(1, 1'b1, 384'd5, 384'd3, 384'd11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 384'd0, 384'd0, P384);
        drive(1, 1'b0, 384'd0, 384'd0, 384'd11);
        sample(0, d, bz, r);
        check_eq("rst_busy0", {383'd0, bz}, 384'd0);
        check_eq("rst_done0", {383'd0, d}, 384'd0);
        check_eq("rst_res0", r, 384'd0);
        sample(1, d, bz, r);
        check_eq("rst_busy1", {383'd0, bz}, 384'd0);
        check_eq("rst_res1", r, 384'd0);

        // Directed cases on the P-384 instance.
        run_op(0, 384'd5, 384'd3, P384, 0, 0, "a5b3");
        run_op(0, 384'd3, 384'd5, P384, 0, 0, "a3b5");
        run_op(0, 384'h1234, 384'h1234, P384, 0, 0, "aeqb");
        run_op(0, 384'd0, P384 - 384'd1, P384, 0, 0, "a0bpm1");
        run_op(0, 384'd7, 384'd2, P384, 4, 0, "ignore_start");
        run_op(0, 384'd10, 384'd4, P384, 0, 0, "back2back");
        run_op(0, 384'd3, 384'd5, P384, 0, 16, "abort");
        run_op(0, 384'd9, 384'd4, P384, 0, 0, "after_abort");

        // Directed cases on the 64/8 instance.
        run_op(1, 384'd5, 384'd3, 384'd101, 0, 0, "s_a5b3");
        run_op(1, 384'd3, 384'd5, 384'd101, 0, 0, "s_a3b5");
        run_op(1, 384'd0, 384'hFFFF_FFFF_FFFF_FFFE, 384'hFFFF_FFFF_FFFF_FFFF, 0, 0, "s_edge");

        // Random vectors against P-384 and against random 384-bit moduli.
        for (int i = 0; i < 300; i++) begin
            rp = (i < 200) ? P384 : (rnd384() >> $urandom_range(0, 300)) | 384'd1;
            ra = rnd384() % rp;
            rb = rnd384() % rp;
            if (i % 17 == 0) rb = ra;
            run_op(0, ra, rb, rp, 0, 0, "rnd384");
        end

        // Random vectors on the narrow instance, mixing wide and small moduli.
        for (int i = 0; i < 800; i++) begin
            sp = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {32'($urandom()), 32'($urandom())};
            if (sp == 64'd0) sp = 64'd1;
            sa = {32'($urandom()), 32'($urandom())} % sp;
            sb = {32'($urandom()), 32'($urandom())} % sp;
            run_op(1, {320'd0, sa}, {320'd0, sb}, {320'd0, sp}, 0, 0, "rnd64");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ecc_mod_sub_serial.md
ECC_MOD_SUB_SERIAL -- requirements
Module: ecc_mod_sub_serial

Interface
REQ-001 SHALL have parameter REG_SIZE, default 384, operand width in bits.
REQ-002 SHALL have parameter RADIX, default 32, word width processed per cycle; REG_SIZE SHALL be an integer multiple of RADIX; NUM_WORDS = REG_SIZE/RADIX.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request pulse; operands sampled in the same cycle.
REQ-006 SHALL have port a_i  input  REG_SIZE  minuend, unsigned, required a_i < p_i.
REQ-007 SHALL have port b_i  input  REG_SIZE  subtrahend, unsigned, required b_i < p_i.
REQ-008 SHALL have port p_i  input  REG_SIZE  modulus, unsigned, nonzero.
REQ-009 SHALL have port busy_o  output  1  high while an operation is in progress.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse when res_o becomes valid.
REQ-011 SHALL have port res_o  output  REG_SIZE  (a - b) mod p; held stable until next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, SUB, ADD, DONE.
REQ-013 In IDLE with start_i=1: latch a_i, b_i, p_i into internal registers, word counter=0, borrow=0, go to SUB.
REQ-014 In IDLE with start_i=0: remain in IDLE, res_o unchanged.
REQ-015 In SUB, each cycle: word w = counter; d_w = a_w - b_w - borrow over RADIX bits; d_w stored into word w of diff register; borrow = 1 iff a_w < b_w + borrow; counter increments.
REQ-016 After word NUM_WORDS-1 in SUB: final borrow=1 -> counter=0, carry=0, go to ADD; final borrow=0 -> go to DONE.
REQ-017 In ADD, each cycle: diff_w = diff_w + p_w + carry over RADIX bits; carry = bit RADIX of sum; counter increments; after word NUM_WORDS-1 go to DONE; final carry discarded.
REQ-018 In DONE: res_o = diff register, done_o=1 for exactly this cycle, next state IDLE.
REQ-019 busy_o SHALL be 1 in SUB, ADD and DONE; 0 in IDLE.
REQ-020 Latency from start_i cycle to done_o cycle SHALL be NUM_WORDS+1 cycles when a >= b, 2*NUM_WORDS+1 when a < b.
REQ-021 start_i while busy_o=1 SHALL be ignored; latched operands unaffected.
REQ-022 start_i in the cycle after done_o SHALL be accepted normally (back-to-back throughput one op per latency+1 cycles).
REQ-023 Word 0 SHALL be the least-significant RADIX bits; counter SHALL be ceil(log2(NUM_WORDS+1)) bits and SHALL not wrap beyond NUM_WORDS-1 within a pass.
REQ-024 Only one RADIX-bit subtract/add datapath SHALL exist; word selection by counter-indexed muxing or shift registers.
REQ-025 Behaviour for a_i >= p_i or b_i >= p_i is unspecified; SHALL not hang: FSM always returns to IDLE within 2*NUM_WORDS+1 cycles.

Reset
REQ-026 reset=1 SHALL force state IDLE, counter=0, borrow/carry=0, busy_o=0, done_o=0, res_o=0, internal operand and diff registers=0.
REQ-027 reset asserted mid-operation (SUB or ADD) SHALL abort it; no done_o pulse issued for the aborted operation.
REQ-028 reset SHALL take priority over start_i in the same cycle.

Verification
REQ-029 a=5, b=3, p=P-384 prime, start -> done_o exactly 13 cycles after start, res_o=2, busy_o high cycles 1..13.
REQ-030 a=3, b=5, p=P-384 -> done_o 25 cycles after start, res_o=p-2.
REQ-031 a=b=0x1234 -> res_o=0, latency 13; a=0, b=p-1 -> res_o=1, latency 25.
REQ-032 start with a=7,b=2, then start_i=1 with a=1,b=9 at cycle 4 -> ignored, res_o=5 at cycle 13; then immediate new start at cycle 14 accepted.
REQ-033 start a=3,b=5, assert reset at cycle 16 (inside ADD) -> next cycle busy_o=0, res_o=0, no done_o; subsequent start a=9,b=4 -> res_o=5.
REQ-034 Random a,b < p (>=1000 vectors, also RADIX=8, REG_SIZE=64) compared against (a - b) mod p reference model, latency per REQ-020.
